// File: rtl/tst_axil_pkg.sv
// Shared types and constants for the test-control AXI4-Lite initiator.
package tst_axil_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdData,
        StRsp
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Test-control register map (test enable, iteration count)
    localparam logic [11:0] ADDR_ONOFF = 12'h20;
    localparam logic [11:0] ADDR_NITE  = 12'h24;

    // States in which the initiator waits on the slave and the timeout runs
    function automatic logic is_wait_state(state_e s);
        return (s == StWrReq) || (s == StWrResp) || (s == StRdReq) || (s == StRdData);
    endfunction

endpackage

// File: rtl/tst_axil_tmo_cnt.sv
// Per-transaction wait counter; flags expiry on the last allowed wait cycle.
module tst_axil_tmo_cnt
    import tst_axil_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic ACLK,
    input  logic ARESET,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] LastCnt = (TIMEOUT_CYCLES > 0) ? CntW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic TmoOn = (TIMEOUT_CYCLES != 0);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count up and saturate at the expiry value
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && TmoOn && (cnt_q != LastCnt)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = TmoOn && enable && (cnt_q == LastCnt);

endmodule

// File: rtl/tst_axil_master.sv
// AXI4-Lite initiator: one register command in, one AXI transaction, one response out.
module tst_axil_master
    import tst_axil_pkg::*;
#(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 12,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   AWADDR,
    output logic                            AWVALID,
    input  logic                            AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] WSTRB,
    output logic                            WVALID,
    input  logic                            WREADY,
    input  logic [1:0]                      BRESP,
    input  logic                            BVALID,
    output logic                            BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   ARADDR,
    output logic                            ARVALID,
    input  logic                            ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]                      RRESP,
    input  logic                            RVALID,
    output logic                            RREADY
);

    localparam int unsigned StrbW = C_M_AXI_DATA_WIDTH / 8;

    state_e                          state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [StrbW-1:0]                wstrb_q, wstrb_d;
    logic                            awvalid_q, awvalid_d;
    logic                            wvalid_q, wvalid_d;
    logic                            arvalid_q, arvalid_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]                      resp_q, resp_d;
    logic                            tmo_q, tmo_d;

    logic cmd_hs;
    logic wait_done;
    logic expired;

    // cmd_ready is masked by reset so no command is taken while ARESET is high
    assign cmd_ready = (state_q == StIdle) && !ARESET;
    assign cmd_hs    = cmd_valid && cmd_ready;

    tst_axil_tmo_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo_cnt (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .clear   (cmd_hs),
        .enable  (is_wait_state(state_q)),
        .expired (expired)
    );

    // Next-state, channel VALIDs and response capture
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        tmo_d     = tmo_q;
        wait_done = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_hs) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = StWrReq;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = StRdReq;
                    end
                end
            end
            StWrReq: begin
                // AW and W retire independently, in any order
                if (awvalid_q && AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && WREADY)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    wait_done = 1'b1;
                    state_d   = StWrResp;
                end
            end
            StWrResp: begin
                if (BVALID) begin
                    wait_done = 1'b1;
                    rdata_d   = '0;
                    resp_d    = BRESP;
                    tmo_d     = 1'b0;
                    state_d   = StRsp;
                end
            end
            StRdReq: begin
                if (ARREADY) begin
                    wait_done = 1'b1;
                    arvalid_d = 1'b0;
                    state_d   = StRdData;
                end
            end
            StRdData: begin
                if (RVALID) begin
                    wait_done = 1'b1;
                    rdata_d   = RDATA;
                    resp_d    = RRESP;
                    tmo_d     = 1'b0;
                    state_d   = StRsp;
                end
            end
            StRsp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort a hung transaction; a handshake on the expiry cycle takes priority
        if (expired && !wait_done) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            arvalid_d = 1'b0;
            rdata_d   = '0;
            resp_d    = RESP_SLVERR;
            tmo_d     = 1'b1;
            state_d   = StRsp;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            tmo_q     <= tmo_d;
        end
    end

    assign AWADDR      = addr_q;
    assign AWVALID     = awvalid_q;
    assign WDATA       = wdata_q;
    assign WSTRB       = wstrb_q;
    assign WVALID      = wvalid_q;
    assign BREADY      = (state_q == StWrResp);
    assign ARADDR      = addr_q;
    assign ARVALID     = arvalid_q;
    assign RREADY      = (state_q == StRdData);
    assign rsp_valid   = (state_q == StRsp);
    assign rsp_rdata   = rdata_q;
    assign rsp_resp    = resp_q;
    assign rsp_timeout = tmo_q;

endmodule

// File: tb/tb_tst_axil_master.sv
// Scoreboard bench for tst_axil_master with a configurable test-register slave.
module tb_tst_axil_master;
    import tst_axil_pkg::*;

    logic        ACLK;
    logic        ARESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [11:0] AWADDR, ARADDR;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    tst_axil_master #(
        .C_M_AXI_ADDR_WIDTH (12),
        .C_M_AXI_DATA_WIDTH (32),
        .TIMEOUT_CYCLES     (16)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .rsp_timeout (rsp_timeout),
        .AWADDR      (AWADDR),
        .AWVALID     (AWVALID),
        .AWREADY     (AWREADY),
        .WDATA       (WDATA),
        .WSTRB       (WSTRB),
        .WVALID      (WVALID),
        .WREADY      (WREADY),
        .BRESP       (BRESP),
        .BVALID      (BVALID),
        .BREADY      (BREADY),
        .ARADDR      (ARADDR),
        .ARVALID     (ARVALID),
        .ARREADY     (ARREADY),
        .RDATA       (RDATA),
        .RRESP       (RRESP),
        .RVALID      (RVALID),
        .RREADY      (RREADY)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        tmo;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Slave configuration and bookkeeping
    int          aw_wait = 0, w_wait = 0, b_wait = 0, r_wait = 0;
    logic        w_after_aw = 1'b0, ar_never = 1'b0;
    int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_awv = 0, n_arv = 0;
    logic [31:0] reg_onoff = 32'h0, reg_nite = 32'h0000_00A5;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial forever begin
        @(posedge ACLK);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    function automatic logic [1:0] resp_for(input logic [11:0] a);
        if (a == ADDR_ONOFF || a == ADDR_NITE) return RESP_OKAY;
        if (a == 12'h30) return RESP_SLVERR;
        return RESP_DECERR;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    // Reactive AXI4-Lite slave: handshakes sampled at negedge, responses driven after posedge
    initial begin : slave
        logic        hs_aw, hs_w, hs_b, hs_ar, hs_r;
        logic        aw_done, w_done, b_pend, r_pend;
        logic [11:0] s_awaddr, s_araddr;
        logic [31:0] s_wdata;
        logic [3:0]  s_wstrb;
        logic [1:0]  b_resp_s;
        int          aw_cnt, w_cnt, b_cnt, r_cnt;
        aw_done = 0; w_done = 0; b_pend = 0; r_pend = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0;
        s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0; b_resp_s = '0;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = '0;
        ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = '0;
        forever begin
            @(negedge ACLK);
            hs_aw = AWVALID && AWREADY;
            hs_w  = WVALID && WREADY;
            hs_b  = BVALID && BREADY;
            hs_ar = ARVALID && ARREADY;
            hs_r  = RVALID && RREADY;
            if (hs_aw) s_awaddr = AWADDR;
            if (hs_w) begin s_wdata = WDATA; s_wstrb = WSTRB; end
            if (hs_ar) s_araddr = ARADDR;
            @(posedge ACLK);
            #1;
            if (ARESET) begin
                aw_done = 0; w_done = 0; b_pend = 0; r_pend = 0; aw_cnt = 0; w_cnt = 0;
                AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
            end else begin
                if (hs_aw) begin aw_done = 1; n_aw++; end
                if (hs_w) begin w_done = 1; n_w++; end
                if (hs_b) begin BVALID = 0; n_b++; end
                if (hs_r) RVALID = 0;
                if (hs_ar) begin r_pend = 1; r_cnt = 0; n_ar++; end
                if (aw_done && w_done) begin
                    if (s_awaddr == ADDR_ONOFF) reg_onoff = merge(reg_onoff, s_wdata, s_wstrb);
                    else if (s_awaddr == ADDR_NITE) reg_nite = merge(reg_nite, s_wdata, s_wstrb);
                    b_resp_s = resp_for(s_awaddr);
                    b_pend = 1; b_cnt = 0; aw_done = 0; w_done = 0;
                end
                if (b_pend) begin
                    if (b_cnt >= b_wait) begin BVALID = 1; BRESP = b_resp_s; b_pend = 0; end
                    else b_cnt++;
                end
                if (r_pend) begin
                    if (r_cnt >= r_wait) begin
                        RVALID = 1;
                        RRESP  = resp_for(s_araddr);
                        RDATA  = (s_araddr == ADDR_ONOFF) ? reg_onoff :
                                 (s_araddr == ADDR_NITE)  ? reg_nite  : 32'h0;
                        r_pend = 0;
                    end else r_cnt++;
                end
                if (AWVALID) begin n_awv++; aw_cnt++; end else aw_cnt = 0;
                if (WVALID) w_cnt++; else w_cnt = 0;
                if (ARVALID) n_arv++;
                AWREADY = AWVALID && (aw_cnt > aw_wait);
                WREADY  = WVALID && (w_cnt > w_wait) && (!w_after_aw || aw_done);
                ARREADY = ARVALID && !ar_never;
            end
        end
    end

    // Monitor: pops the scoreboard on every response handshake
    initial begin : monitor
        logic prev_v;
        int   first_cyc;
        exp_t e;
        prev_v = 0;
        first_cyc = 0;
        forever begin
            @(negedge ACLK);
            if (rsp_valid && !prev_v) first_cyc = cyc;
            if (rsp_valid && rsp_ready && !ARESET) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got rdata 0x%08h, expected no response", rsp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
                    chk("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
                    chk("rsp_latency", 32'(first_cyc - e.acc), 32'(e.lat));
                end
            end
            prev_v = rsp_valid;
        end
    end

    task automatic clr_counts();
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_awv = 0; n_arv = 0;
    endtask

    // Present one command, push its expected response once it is accepted
    task automatic send_cmd(input logic wr, input logic [11:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [31:0] e_rdata,
                            input logic [1:0] e_resp, input logic e_tmo, input int e_lat);
        int   n;
        exp_t e;
        n = 0;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        do begin
            @(negedge ACLK);
            n++;
        end while (!cmd_ready && n < 50);
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL cmd_accept: got cmd_ready 0, expected 1 within 50 cycles");
        end else begin
            e.rdata = e_rdata; e.resp = e_resp; e.tmo = e_tmo; e.lat = e_lat; e.acc = cyc;
            exp_q.push_back(e);
        end
        @(posedge ACLK);
        #1;
        cmd_valid = 0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge ACLK);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rsp_wait: got %0d pending, expected 0 within 100 cycles", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin : stim
        int n;
        ARESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
        cmd_wstrb = '0; rsp_ready = 1;
        repeat (2) @(posedge ACLK);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_valids", 32'({AWVALID, WVALID, ARVALID}), 32'd0);
        chk("rst_readys", 32'({BREADY, RREADY}), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_fields", {rsp_rdata[29:0], rsp_resp} | 32'(rsp_timeout), 32'd0);
        ARESET = 0;
        #1;
        chk("rst_cmd_ready_after", 32'(cmd_ready), 32'd1);
        @(posedge ACLK);
        #1;

        // Write 0x20 = 1; slave accepts W only after AW
        w_after_aw = 1;
        clr_counts();
        send_cmd(1, ADDR_ONOFF, 32'h1, 4'hF, 32'h0, RESP_OKAY, 0, 4);
        wait_rsp();
        chk("test_en", 32'(reg_onoff[0]), 32'd1);
        chk("wr1_b_count", 32'(n_b), 32'd1);

        // Read iteration count
        send_cmd(0, ADDR_NITE, 32'h0, 4'h0, 32'h0000_00A5, RESP_OKAY, 0, 3);
        wait_rsp();

        // W accepted a cycle before AW; partial strobes
        w_after_aw = 0; aw_wait = 1;
        clr_counts();
        send_cmd(1, ADDR_NITE, 32'h1234_5678, 4'h3, 32'h0, RESP_OKAY, 0, 4);
        wait_rsp();
        chk("wfirst_awvalid_cycles", 32'(n_awv), 32'd2);
        chk("wfirst_aw_count", 32'(n_aw), 32'd1);
        chk("wfirst_w_count", 32'(n_w), 32'd1);
        chk("wfirst_b_count", 32'(n_b), 32'd1);
        chk("nite_value", reg_nite, 32'h0000_5678);
        aw_wait = 0;

        // Error responses pass through
        send_cmd(1, 12'h30, 32'hDEAD_BEEF, 4'hF, 32'h0, RESP_SLVERR, 0, 3);
        wait_rsp();
        send_cmd(0, ADDR_NITE, 32'h0, 4'h0, 32'h0000_5678, RESP_OKAY, 0, 3);
        wait_rsp();

        // Hung AR: abort after 16 wait cycles, then recover
        ar_never = 1;
        clr_counts();
        send_cmd(0, ADDR_NITE, 32'h0, 4'h0, 32'h0, RESP_SLVERR, 1, 17);
        wait_rsp();
        chk("tmo_arvalid_cycles", 32'(n_arv), 32'd16);
        chk("tmo_ar_count", 32'(n_ar), 32'd0);
        ar_never = 0;
        send_cmd(0, ADDR_ONOFF, 32'h0, 4'h0, 32'h1, RESP_OKAY, 0, 3);
        wait_rsp();

        // Backpressured response with a new command waiting
        rsp_ready = 0;
        send_cmd(0, ADDR_ONOFF, 32'h0, 4'h0, 32'h1, RESP_OKAY, 0, 3);
        cmd_valid = 1; cmd_write = 1; cmd_addr = ADDR_ONOFF; cmd_wdata = 32'h0; cmd_wstrb = 4'hF;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!rsp_valid && n < 20);
        for (int i = 0; i < 5; i++) begin
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_rdata", rsp_rdata, 32'h1);
            chk("hold_rsp_resp", 32'(rsp_resp), 32'd0);
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("hold_no_aw_ar", 32'({AWVALID, ARVALID}), 32'd0);
            if (i < 4) @(negedge ACLK);
        end
        @(posedge ACLK);
        #1;
        rsp_ready = 1;
        send_cmd(1, ADDR_ONOFF, 32'h0, 4'hF, 32'h0, RESP_OKAY, 0, 3);
        wait_rsp();
        chk("test_en_cleared", reg_onoff, 32'h0);

        // Reset while waiting for B
        b_wait = 10;
        send_cmd(1, ADDR_ONOFF, 32'h1, 4'hF, 32'h0, RESP_OKAY, 0, 0);
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!BREADY && n < 20);
        chk("rst_mid_bready_seen", 32'(BREADY), 32'd1);
        @(posedge ACLK);
        #1;
        ARESET = 1;
        exp_q.delete();
        @(posedge ACLK);
        #1;
        chk("midrst_valids", 32'({AWVALID, WVALID, ARVALID}), 32'd0);
        chk("midrst_readys", 32'({BREADY, RREADY}), 32'd0);
        chk("midrst_rsp", 32'({rsp_valid, rsp_timeout, rsp_resp}), 32'd0);
        chk("midrst_rdata", rsp_rdata, 32'h0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        ARESET = 0;
        b_wait = 0;
        @(negedge ACLK);
        chk("postrst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge ACLK);
        #1;

        send_cmd(0, 12'h40, 32'h0, 4'h0, 32'h0, RESP_DECERR, 0, 3);
        wait_rsp();
        send_cmd(0, ADDR_ONOFF, 32'h0, 4'h0, 32'h1, RESP_OKAY, 0, 3);
        wait_rsp();

        repeat (3) @(posedge ACLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
